// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core load/store path (port 0) and a
// loader/debug master (port 1); each access runs IDLE -> ISSUE -> [WAIT] -> [RESP].
module dmem_arbiter #(
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_wren,
  input  logic [9:0]  p0_addr,
  input  logic [31:0] p0_din,
  input  logic [3:0]  p0_be,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_dout,
  input  logic        p1_req,
  input  logic        p1_wren,
  input  logic [9:0]  p1_addr,
  input  logic [31:0] p1_din,
  input  logic [3:0]  p1_be,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_dout,
  output logic [9:0]  dmem_addr,
  output logic [31:0] dmem_din,
  output logic [3:0]  dmem_be,
  output logic        dmem_wren,
  input  logic [31:0] dmem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] LP_CNT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  state_t      r_state, w_state_next;
  logic        r_last_winner, w_last_winner;
  logic        r_winner, w_winner;
  logic [2:0]  r_cnt, w_cnt;
  logic [9:0]  r_dmem_addr, w_dmem_addr;
  logic [31:0] r_dmem_din, w_dmem_din;
  logic [3:0]  r_dmem_be, w_dmem_be;
  logic        r_dmem_wren, w_dmem_wren;
  logic        r_p0_gnt, w_p0_gnt, r_p1_gnt, w_p1_gnt;
  logic        r_p0_rvalid, w_p0_rvalid, r_p1_rvalid, w_p1_rvalid;
  logic [31:0] r_p0_dout, w_p0_dout, r_p1_dout, w_p1_dout;
  logic        r_busy, w_busy;

  logic w_any_req;
  logic w_pick1;
  logic w_sample;

  assign w_any_req = p0_req | p1_req;
  // Round-robin favours the port that did not win last; fixed priority ignores history.
  assign w_pick1 = (PRIO_MODE != 0) ? ~p0_req
                                    : (p1_req & (~p0_req | ~r_last_winner));
  assign w_sample = ((r_state == S_ISSUE) && !r_dmem_wren && (RD_LAT == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == 3'd0));

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last_winner <= 1'b1;
      r_winner      <= 1'b0;
      r_cnt         <= 3'd0;
      r_dmem_addr   <= 10'd0;
      r_dmem_din    <= 32'd0;
      r_dmem_be     <= 4'd0;
      r_dmem_wren   <= 1'b0;
      r_p0_gnt      <= 1'b0;
      r_p1_gnt      <= 1'b0;
      r_p0_rvalid   <= 1'b0;
      r_p1_rvalid   <= 1'b0;
      r_p0_dout     <= 32'd0;
      r_p1_dout     <= 32'd0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_last_winner <= w_last_winner;
      r_winner      <= w_winner;
      r_cnt         <= w_cnt;
      r_dmem_addr   <= w_dmem_addr;
      r_dmem_din    <= w_dmem_din;
      r_dmem_be     <= w_dmem_be;
      r_dmem_wren   <= w_dmem_wren;
      r_p0_gnt      <= w_p0_gnt;
      r_p1_gnt      <= w_p1_gnt;
      r_p0_rvalid   <= w_p0_rvalid;
      r_p1_rvalid   <= w_p1_rvalid;
      r_p0_dout     <= w_p0_dout;
      r_p1_dout     <= w_p1_dout;
      r_busy        <= w_busy;
    end
  end

  // Next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_next = S_ISSUE;
      S_ISSUE: begin
        if (r_dmem_wren)      w_state_next = S_IDLE;
        else if (RD_LAT == 0) w_state_next = S_RESP;
        else                  w_state_next = S_WAIT;
      end
      S_WAIT:  if (r_cnt == 3'd0) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output next-values
  always_comb begin
    w_last_winner = r_last_winner;
    w_winner      = r_winner;
    w_cnt         = r_cnt;
    w_dmem_addr   = r_dmem_addr;
    w_dmem_din    = r_dmem_din;
    w_dmem_be     = r_dmem_be;
    w_dmem_wren   = 1'b0;
    w_p0_gnt      = 1'b0;
    w_p1_gnt      = 1'b0;
    w_p0_rvalid   = 1'b0;
    w_p1_rvalid   = 1'b0;
    w_p0_dout     = r_p0_dout;
    w_p1_dout     = r_p1_dout;
    w_busy        = (w_state_next != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_winner      = w_pick1;
          w_last_winner = w_pick1;
          w_p0_gnt      = ~w_pick1;
          w_p1_gnt      = w_pick1;
          w_dmem_addr   = w_pick1 ? p1_addr : p0_addr;
          w_dmem_din    = w_pick1 ? p1_din  : p0_din;
          w_dmem_be     = w_pick1 ? p1_be   : p0_be;
          w_dmem_wren   = w_pick1 ? p1_wren : p0_wren;
        end else begin
          w_dmem_be = 4'd0;
        end
      end
      S_ISSUE: w_cnt = LP_CNT_INIT;
      S_WAIT:  if (r_cnt != 3'd0) w_cnt = r_cnt - 3'd1;
      default: ;
    endcase
    if (w_sample) begin
      if (r_winner) begin
        w_p1_dout   = dmem_dout;
        w_p1_rvalid = 1'b1;
      end else begin
        w_p0_dout   = dmem_dout;
        w_p0_rvalid = 1'b1;
      end
    end
  end

  assign p0_gnt    = r_p0_gnt;
  assign p1_gnt    = r_p1_gnt;
  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_dout   = r_p0_dout;
  assign p1_dout   = r_p1_dout;
  assign dmem_addr = r_dmem_addr;
  assign dmem_din  = r_dmem_din;
  assign dmem_be   = r_dmem_be;
  assign dmem_wren = r_dmem_wren;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: four arbiter configurations share one stimulus bus, each with
// its own behavioural memory; every test resets and checks the relevant instance.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        p0_req, p0_wren, p1_req, p1_wren;
  logic [9:0]  p0_addr, p1_addr;
  logic [31:0] p0_din, p1_din;
  logic [3:0]  p0_be, p1_be;

  logic [3:0]  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, dmem_wren, busy;
  logic [31:0] p0_dout [4];
  logic [31:0] p1_dout [4];
  logic [31:0] dmem_din [4];
  logic [31:0] dmem_dout [4];
  logic [9:0]  dmem_addr [4];
  logic [3:0]  dmem_be [4];

  int checks = 0;
  int errors = 0;

  // 0: RD_LAT=1 RR   1: RD_LAT=1 fixed prio   2: RD_LAT=3 RR   3: RD_LAT=0 RR
  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int LAT = (gi == 2) ? 3 : ((gi == 3) ? 0 : 1);
    localparam int PRI = (gi == 1) ? 1 : 0;
    logic [31:0] mem [0:1023];

    dmem_arbiter #(.RD_LAT(LAT), .PRIO_MODE(PRI)) u_dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_wren(p0_wren), .p0_addr(p0_addr), .p0_din(p0_din), .p0_be(p0_be),
      .p0_gnt(p0_gnt[gi]), .p0_rvalid(p0_rvalid[gi]), .p0_dout(p0_dout[gi]),
      .p1_req(p1_req), .p1_wren(p1_wren), .p1_addr(p1_addr), .p1_din(p1_din), .p1_be(p1_be),
      .p1_gnt(p1_gnt[gi]), .p1_rvalid(p1_rvalid[gi]), .p1_dout(p1_dout[gi]),
      .dmem_addr(dmem_addr[gi]), .dmem_din(dmem_din[gi]), .dmem_be(dmem_be[gi]),
      .dmem_wren(dmem_wren[gi]), .dmem_dout(dmem_dout[gi]), .busy(busy[gi])
    );

    always @(posedge clk) begin
      if (dmem_wren[gi]) begin
        for (int b = 0; b < 4; b++)
          if (dmem_be[gi][b]) mem[dmem_addr[gi]][8*b +: 8] <= dmem_din[gi][8*b +: 8];
      end
    end
    assign dmem_dout[gi] = mem[dmem_addr[gi]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    p0_req = 1'b0; p0_wren = 1'b0; p0_addr = 10'd0; p0_din = 32'd0; p0_be = 4'd0;
    p1_req = 1'b0; p1_wren = 1'b0; p1_addr = 10'd0; p1_din = 32'd0; p1_be = 4'd0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic preload_write(input logic port, input logic [9:0] a, input logic [31:0] d);
    if (port) begin
      p1_req = 1'b1; p1_wren = 1'b1; p1_addr = a; p1_din = d; p1_be = 4'hF;
    end else begin
      p0_req = 1'b1; p0_wren = 1'b1; p0_addr = a; p0_din = d; p0_be = 4'hF;
    end
    tick();
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tick();
    $display("preload port %0d addr %h data %h", port, a, d);
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (p0_gnt !== 4'd0) begin errors++; $display("FAIL reset_p0_gnt got %b exp 0000", p0_gnt); end
    checks++; if (p1_gnt !== 4'd0) begin errors++; $display("FAIL reset_p1_gnt got %b exp 0000", p1_gnt); end
    checks++; if ((p0_rvalid | p1_rvalid) !== 4'd0) begin errors++; $display("FAIL reset_rvalid got %b/%b exp 0", p0_rvalid, p1_rvalid); end
    checks++; if ((busy | dmem_wren) !== 4'd0) begin errors++; $display("FAIL reset_busy_wren got %b/%b exp 0", busy, dmem_wren); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ((p0_dout[i] | p1_dout[i] | dmem_din[i]) !== 32'd0 || dmem_addr[i] !== 10'd0 || dmem_be[i] !== 4'd0) begin
        errors++;
        $display("FAIL reset_data inst %0d got dout %h/%h din %h addr %h be %h exp 0", i, p0_dout[i], p1_dout[i], dmem_din[i], dmem_addr[i], dmem_be[i]);
      end
    end
    $display("reset checked");
  endtask

  task automatic test_write_p0;
    do_reset();
    p0_req = 1'b1; p0_wren = 1'b1; p0_addr = 10'h001; p0_din = 32'hDEADBEEF; p0_be = 4'hF;
    tick();
    p0_req = 1'b0;
    checks++; if (p0_gnt[0] !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", p0_gnt[0]); end
    checks++; if (dmem_wren[0] !== 1'b1 || dmem_addr[0] !== 10'h001 || dmem_din[0] !== 32'hDEADBEEF || dmem_be[0] !== 4'hF) begin
      errors++; $display("FAIL wr_cmd got wren %b addr %h din %h be %h exp 1 001 deadbeef f", dmem_wren[0], dmem_addr[0], dmem_din[0], dmem_be[0]); end
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL wr_busy got %b exp 1", busy[0]); end
    checks++; if (p1_gnt[0] !== 1'b0 || p1_rvalid[0] !== 1'b0 || p1_dout[0] !== 32'd0) begin
      errors++; $display("FAIL wr_p1_quiet got gnt %b rvalid %b dout %h exp 0", p1_gnt[0], p1_rvalid[0], p1_dout[0]); end
    tick();
    checks++; if (p0_gnt[0] !== 1'b0 || dmem_wren[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL wr_one_cycle got gnt %b wren %b busy %b exp 0 0 0", p0_gnt[0], dmem_wren[0], busy[0]); end
    checks++; if (g_dut[0].mem[10'h001] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem got %h exp deadbeef", g_dut[0].mem[10'h001]); end
    checks++; if (p1_gnt[0] !== 1'b0 || p1_rvalid[0] !== 1'b0 || p0_rvalid[0] !== 1'b0) begin
      errors++; $display("FAIL wr_no_resp got p1g %b p1v %b p0v %b exp 0", p1_gnt[0], p1_rvalid[0], p0_rvalid[0]); end
    tick();
    checks++; if (p0_gnt[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL wr_no_regrant got gnt %b busy %b exp 0", p0_gnt[0], busy[0]); end
    $display("p0 write addr 001 data deadbeef");
  endtask

  task automatic test_read_p1;
    do_reset();
    preload_write(1'b1, 10'h010, 32'h12345678);
    p1_req = 1'b1; p1_wren = 1'b0; p1_addr = 10'h010; p1_be = 4'hF;
    tick();  // E0
    p1_req = 1'b0;
    checks++; if (p1_gnt[0] !== 1'b1 || dmem_wren[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL rd_e0 got gnt %b wren %b busy %b exp 1 0 1", p1_gnt[0], dmem_wren[0], busy[0]); end
    tick();  // E1
    checks++; if (p1_gnt[0] !== 1'b0 || p1_rvalid[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL rd_e1 got gnt %b rvalid %b busy %b exp 0 0 1", p1_gnt[0], p1_rvalid[0], busy[0]); end
    tick();  // E2
    checks++; if (p1_rvalid[0] !== 1'b1 || p1_dout[0] !== 32'h12345678 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL rd_e2 got rvalid %b dout %h busy %b exp 1 12345678 1", p1_rvalid[0], p1_dout[0], busy[0]); end
    checks++; if (p0_rvalid[0] !== 1'b0 || p0_dout[0] !== 32'd0) begin
      errors++; $display("FAIL rd_p0_quiet got rvalid %b dout %h exp 0", p0_rvalid[0], p0_dout[0]); end
    tick();  // E3
    checks++; if (p1_rvalid[0] !== 1'b0 || busy[0] !== 1'b0 || p1_dout[0] !== 32'h12345678) begin
      errors++; $display("FAIL rd_e3 got rvalid %b busy %b dout %h exp 0 0 12345678", p1_rvalid[0], busy[0], p1_dout[0]); end
    $display("p1 read addr 010 data %h", p1_dout[0]);
  endtask

  task automatic test_round_robin;
    int n0 = 0;
    int n1 = 0;
    int exp_port = 0;
    int overlap = 0;
    int port;
    do_reset();
    p0_req = 1'b1; p0_wren = 1'b1; p0_addr = 10'h020; p0_din = 32'h0; p0_be = 4'hF;
    p1_req = 1'b1; p1_wren = 1'b1; p1_addr = 10'h040; p1_din = 32'h100; p1_be = 4'hF;
    for (int cyc = 0; cyc < 80 && (n0 < 8 || n1 < 8); cyc++) begin
      tick();
      if (p0_gnt[0] && p1_gnt[0]) overlap++;
      if (p0_gnt[0] || p1_gnt[0]) begin
        port = p1_gnt[0] ? 1 : 0;
        checks++;
        if (port != exp_port) begin errors++; $display("FAIL rr_order grant %0d got port %0d exp %0d", n0 + n1, port, exp_port); end
        $display("rr grant %0d port %0d", n0 + n1, port);
        exp_port = 1 - exp_port;
        if (port == 1) begin n1++; p1_din = p1_din + 32'd1; end
        else begin n0++; p0_din = p0_din + 32'd1; end
        if (n0 >= 8) p0_req = 1'b0;
        if (n1 >= 8) p1_req = 1'b0;
      end
    end
    idle_inputs();
    checks++; if (n0 != 8) begin errors++; $display("FAIL rr_count_p0 got %0d exp 8", n0); end
    checks++; if (n1 != 8) begin errors++; $display("FAIL rr_count_p1 got %0d exp 8", n1); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL rr_overlap got %0d exp 0", overlap); end
    tick();
    tick();
  endtask

  task automatic test_priority;
    int n0 = 0;
    int p1seen = 0;
    do_reset();
    p0_req = 1'b1; p0_wren = 1'b1; p0_addr = 10'h050; p0_din = 32'h5; p0_be = 4'hF;
    p1_req = 1'b1; p1_wren = 1'b1; p1_addr = 10'h060; p1_din = 32'h6; p1_be = 4'hF;
    for (int cyc = 0; cyc < 60 && n0 < 6; cyc++) begin
      tick();
      if (p1_gnt[1]) p1seen++;
      if (p0_gnt[1]) begin
        n0++;
        $display("prio grant port 0 #%0d", n0);
        if (n0 == 6) p0_req = 1'b0;
      end
    end
    checks++; if (n0 != 6) begin errors++; $display("FAIL prio_p0_count got %0d exp 6", n0); end
    checks++; if (p1seen != 0) begin errors++; $display("FAIL prio_p1_starved got %0d grants exp 0", p1seen); end
    tick();
    checks++; if (p1_gnt[1] !== 1'b0) begin errors++; $display("FAIL prio_p1_early got %b exp 0", p1_gnt[1]); end
    tick();
    checks++; if (p1_gnt[1] !== 1'b1) begin errors++; $display("FAIL prio_p1_after got %b exp 1", p1_gnt[1]); end
    $display("prio grant port 1");
    p1_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_abort;
    int rv = 0;
    do_reset();
    p0_req = 1'b1; p0_wren = 1'b0; p0_addr = 10'h005; p0_be = 4'hF;
    tick();  // E0
    p0_req = 1'b0;
    checks++; if (p0_gnt[2] !== 1'b1) begin errors++; $display("FAIL abort_gnt got %b exp 1", p0_gnt[2]); end
    tick();  // E1
    tick();  // E2, still waiting
    checks++; if (busy[2] !== 1'b1 || p0_rvalid[2] !== 1'b0) begin
      errors++; $display("FAIL abort_wait got busy %b rvalid %b exp 1 0", busy[2], p0_rvalid[2]); end
    rst = 1'b1;
    #1;
    checks++; if (p0_gnt[2] !== 1'b0 || p1_gnt[2] !== 1'b0 || p0_rvalid[2] !== 1'b0 || p1_rvalid[2] !== 1'b0 || busy[2] !== 1'b0 || dmem_wren[2] !== 1'b0) begin
      errors++; $display("FAIL abort_async got gnt %b%b rvalid %b%b busy %b wren %b exp 0", p0_gnt[2], p1_gnt[2], p0_rvalid[2], p1_rvalid[2], busy[2], dmem_wren[2]); end
    checks++; if (dmem_addr[2] !== 10'd0 || dmem_be[2] !== 4'd0 || p0_dout[2] !== 32'd0) begin
      errors++; $display("FAIL abort_data got addr %h be %h dout %h exp 0", dmem_addr[2], dmem_be[2], p0_dout[2]); end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (p0_rvalid[2]) rv++;
    end
    checks++; if (rv != 0) begin errors++; $display("FAIL abort_no_rvalid got %0d exp 0", rv); end
    p0_req = 1'b1; p0_wren = 1'b1; p0_addr = 10'h007; p0_din = 32'h7; p0_be = 4'hF;
    p1_req = 1'b1; p1_wren = 1'b1; p1_addr = 10'h008; p1_din = 32'h8; p1_be = 4'hF;
    tick();
    checks++; if (p0_gnt[2] !== 1'b1 || p1_gnt[2] !== 1'b0) begin
      errors++; $display("FAIL abort_first_winner got p0 %b p1 %b exp 1 0", p0_gnt[2], p1_gnt[2]); end
    $display("post-reset grant p0 %b p1 %b", p0_gnt[2], p1_gnt[2]);
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_rdlat0;
    int waited = 0;
    int wren_seen = 0;
    do_reset();
    preload_write(1'b0, 10'h3FF, 32'hA5A5A5A5);
    p0_req = 1'b1; p0_wren = 1'b0; p0_addr = 10'h3FF; p0_be = 4'hF;
    tick();  // E0
    if (dmem_wren[3]) wren_seen++;
    checks++; if (p0_gnt[3] !== 1'b1) begin errors++; $display("FAIL lat0_rd_gnt got %b exp 1", p0_gnt[3]); end
    p0_wren = 1'b1; p0_din = 32'h5A5A5A5A;  // next command queued, req stays high
    tick();  // E1
    if (dmem_wren[3]) wren_seen++;
    checks++; if (p0_rvalid[3] !== 1'b1 || p0_dout[3] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL lat0_rd_data got rvalid %b dout %h exp 1 a5a5a5a5", p0_rvalid[3], p0_dout[3]); end
    checks++; if (p0_gnt[3] !== 1'b0) begin errors++; $display("FAIL lat0_early_gnt got %b exp 0", p0_gnt[3]); end
    checks++; if (wren_seen != 0) begin errors++; $display("FAIL lat0_rd_wren got %0d cycles exp 0", wren_seen); end
    $display("p0 read addr 3ff data %h", p0_dout[3]);
    for (int i = 0; i < 4 && p0_gnt[3] !== 1'b1; i++) begin
      tick();
      waited++;
    end
    checks++; if (p0_gnt[3] !== 1'b1 || dmem_wren[3] !== 1'b1 || p0_rvalid[3] !== 1'b0) begin
      errors++; $display("FAIL lat0_wr_gnt got gnt %b wren %b rvalid %b after %0d cycles exp 1 1 0", p0_gnt[3], dmem_wren[3], p0_rvalid[3], waited); end
    p0_req = 1'b0;
    tick();
    checks++; if (g_dut[3].mem[10'h3FF] !== 32'h5A5A5A5A || p0_dout[3] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL lat0_wr_mem got mem %h dout %h exp 5a5a5a5a a5a5a5a5", g_dut[3].mem[10'h3FF], p0_dout[3]); end
    $display("p0 write addr 3ff data 5a5a5a5a");
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_write_p0();
    test_read_p1();
    test_round_robin();
    test_priority();
    test_reset_abort();
    test_rdlat0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
